// File: rtl/layer_arb_pkg.sv
// Shared types and defaults for the layer priority arbiter.
// Holds the config/flash FSM state enums, default sizing and the
// identity-table builder used to reset the priority tables.
package layer_arb_pkg;

  localparam int DEF_NUM_LAYERS = 8;
  localparam int DEF_LAYER_W    = 3;
  // Upper bound on the flattened table width the builder can produce.
  localparam int MAX_TABLE_BITS = 256;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } flash_state_t;

  // Flattened table where slot i holds layer index i (w bits per slot).
  function automatic logic [MAX_TABLE_BITS-1:0] identity_table(input int num, input int w);
    logic [MAX_TABLE_BITS-1:0] t;
    t = '0;
    for (int i = 0; i < num; i++) begin
      for (int b = 0; b < w; b++) begin
        if ((i * w + b) < MAX_TABLE_BITS) t[i*w+b] = i[b];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/flash_sequencer.sv
// Frame-counted full-screen flash sequencer.
// A trigger (re)loads the frame counter and turns the flash on; each
// start-of-frame while on consumes one frame. The trigger beats a
// coincident start-of-frame, so a retrigger never loses a frame.
module flash_sequencer
  import layer_arb_pkg::*;
#(
  parameter int FLASH_FRAMES = 6
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic flash_trigger,
  output logic flashActive
);

  localparam int CNT_W = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);

  flash_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and frame counter registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: trigger reloads from any state, frames count down while on.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flashActive = (state_q == ON);
    if (flash_trigger) begin
      state_d = ON;
      cnt_d   = CNT_W'(FLASH_FRAMES);
    end else if (state_q == ON && startOfFrame) begin
      if (cnt_q <= CNT_W'(1)) begin
        state_d = OFF;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/layer_priority_arbiter.sv
// Runtime-configurable per-pixel layer arbiter with frame-synchronous
// table commit and a full-screen flash overlay.
// Optional build macro LAYER_PRIORITY_DEBUG_EN adds a dbg_falseColor input
// that paints each winning pixel with a colour derived from its layer index.
//
// Config handshake: a write is accepted in any cycle where cfg_valid and
// cfg_ready are both high; cfg_ready is high only while no commit is
// pending, so writes stall (cfg_valid may be held) until the commit lands.
module layer_priority_arbiter
  import layer_arb_pkg::*;
#(
  parameter int         NUM_LAYERS   = DEF_NUM_LAYERS,
  parameter int         LAYER_W      = DEF_LAYER_W,
  parameter int         FLASH_FRAMES = 6,
  parameter logic [7:0] FLASH_RGB    = 8'hFF
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [NUM_LAYERS-1:0]   drawReq,
  input  logic [8*NUM_LAYERS-1:0] layerRGB,
  input  logic [7:0]              backGroundRGB,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [LAYER_W-1:0]      cfg_slot,
  input  logic [LAYER_W-1:0]      cfg_layer,
  input  logic                    cfg_enable,
  input  logic                    cfg_commit,
  input  logic                    flash_trigger,
`ifdef LAYER_PRIORITY_DEBUG_EN
  input  logic                    dbg_falseColor,
`endif
  output logic [7:0]              rgbOut,
  output logic                    winnerValid,
  output logic [LAYER_W-1:0]      winnerIdx,
  output logic                    commitBusy
);

  localparam int TBL_W  = NUM_LAYERS * LAYER_W;
  localparam int NSPACE = 2 ** LAYER_W;
  localparam logic [MAX_TABLE_BITS-1:0] ID_FULL  = identity_table(NUM_LAYERS, LAYER_W);
  localparam logic [TBL_W-1:0]          ID_TABLE = ID_FULL[TBL_W-1:0];

  cfg_state_t              cfg_state_q, cfg_state_d;
  logic [TBL_W-1:0]        act_tbl_q;
  logic [TBL_W-1:0]        shd_tbl_q, shd_tbl_d;
  logic [NUM_LAYERS-1:0]   act_en_q;
  logic [NUM_LAYERS-1:0]   shd_en_q, shd_en_d;
  logic                    load_active;
  logic                    cfg_hs;
  logic                    slot_ok, layer_ok;

  logic [NSPACE-1:0]       req_ext, en_ext;
  logic [LAYER_W-1:0]      entry;
  logic                    win_found;
  logic [LAYER_W-1:0]      win_idx;
  logic [7:0]              pix_rgb_d;
  logic                    flash_active;

  logic [7:0]              rgb_q;
  logic                    valid_q;
  logic [LAYER_W-1:0]      idx_q;

  // Config FSM plus shadow table registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cfg_state_q <= IDLE;
      shd_tbl_q   <= ID_TABLE;
      shd_en_q    <= '1;
    end else begin
      cfg_state_q <= cfg_state_d;
      shd_tbl_q   <= shd_tbl_d;
      shd_en_q    <= shd_en_d;
    end
  end

  // Config next-state: shadow writes in IDLE, commit waits for start of frame.
  always_comb begin
    cfg_state_d = cfg_state_q;
    shd_tbl_d   = shd_tbl_q;
    shd_en_d    = shd_en_q;
    load_active = 1'b0;
    cfg_ready   = (cfg_state_q == IDLE);
    commitBusy  = (cfg_state_q == PENDING);
    cfg_hs      = cfg_valid && cfg_ready;
    slot_ok     = 1'b0;
    layer_ok    = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (cfg_slot == LAYER_W'(i))  slot_ok  = 1'b1;
      if (cfg_layer == LAYER_W'(i)) layer_ok = 1'b1;
    end
    case (cfg_state_q)
      IDLE: begin
        // Out-of-range slot or layer still completes the handshake but writes nothing.
        if (cfg_hs && slot_ok && layer_ok) begin
          for (int s = 0; s < NUM_LAYERS; s++) begin
            if (cfg_slot == LAYER_W'(s)) shd_tbl_d[s*LAYER_W +: LAYER_W] = cfg_layer;
          end
          for (int l = 0; l < NUM_LAYERS; l++) begin
            if (cfg_layer == LAYER_W'(l)) shd_en_d[l] = cfg_enable;
          end
        end
        if (cfg_commit) cfg_state_d = PENDING;
      end
      PENDING: begin
        if (startOfFrame) begin
          cfg_state_d = IDLE;
          load_active = 1'b1;
        end
      end
      default: cfg_state_d = IDLE;
    endcase
  end

  // Active table: only ever loaded from shadow at a start-of-frame commit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      act_tbl_q <= ID_TABLE;
      act_en_q  <= '1;
    end else if (load_active) begin
      act_tbl_q <= shd_tbl_q;
      act_en_q  <= shd_en_q;
    end
  end

  // Priority scan: first slot whose layer requests and is enabled wins.
  // Zero-extending request/enable to the full index space makes any
  // out-of-range table entry lose automatically.
  always_comb begin
    req_ext   = NSPACE'(drawReq);
    en_ext    = NSPACE'(act_en_q);
    entry     = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int s = 0; s < NUM_LAYERS; s++) begin
      entry = act_tbl_q[s*LAYER_W +: LAYER_W];
      if (!win_found && req_ext[entry] && en_ext[entry]) begin
        win_found = 1'b1;
        win_idx   = entry;
      end
    end
  end

  // Pixel colour: winner or background, optional false colour, flash on top.
  always_comb begin
    pix_rgb_d = backGroundRGB;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (win_found && win_idx == LAYER_W'(l)) pix_rgb_d = layerRGB[l*8 +: 8];
    end
`ifdef LAYER_PRIORITY_DEBUG_EN
    if (dbg_falseColor && win_found) begin
      pix_rgb_d = {3'(win_idx), 3'(win_idx), 2'(win_idx)};
    end
`endif
    if (flash_active) pix_rgb_d = FLASH_RGB;
  end

  // Registered pixel outputs: one clock from inputs to rgbOut.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q   <= 8'h00;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      rgb_q   <= pix_rgb_d;
      valid_q <= win_found;
      idx_q   <= win_idx;
    end
  end

  assign rgbOut      = rgb_q;
  assign winnerValid = valid_q;
  assign winnerIdx   = idx_q;

  flash_sequencer #(
    .FLASH_FRAMES (FLASH_FRAMES)
  ) u_flash (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .flash_trigger (flash_trigger),
    .flashActive   (flash_active)
  );

endmodule

// File: tb/tb_layer_priority_arbiter.sv
// Bench for layer_priority_arbiter: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the arbiter.
module tb_layer_priority_arbiter;

  localparam int NL = 8;
  localparam int LW = 3;
  localparam int FF = 6;

  // Clock / reset
  logic clk    = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  logic              startOfFrame  = 1'b0;
  logic [NL-1:0]     drawReq       = '0;
  logic [8*NL-1:0]   layerRGB      = '0;
  logic [7:0]        backGroundRGB = 8'h03;
  logic              cfg_valid     = 1'b0;
  logic              cfg_ready;
  logic [LW-1:0]     cfg_slot      = '0;
  logic [LW-1:0]     cfg_layer     = '0;
  logic              cfg_enable    = 1'b0;
  logic              cfg_commit    = 1'b0;
  logic              flash_trigger = 1'b0;
  logic [7:0]        rgbOut;
  logic              winnerValid;
  logic [LW-1:0]     winnerIdx;
  logic              commitBusy;

  layer_priority_arbiter #(
    .NUM_LAYERS   (NL),
    .LAYER_W      (LW),
    .FLASH_FRAMES (FF),
    .FLASH_RGB    (8'hFF)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .drawReq       (drawReq),
    .layerRGB      (layerRGB),
    .backGroundRGB (backGroundRGB),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_slot      (cfg_slot),
    .cfg_layer     (cfg_layer),
    .cfg_enable    (cfg_enable),
    .cfg_commit    (cfg_commit),
    .flash_trigger (flash_trigger),
    .rgbOut        (rgbOut),
    .winnerValid   (winnerValid),
    .winnerIdx     (winnerIdx),
    .commitBusy    (commitBusy)
  );

  // Scoreboard state
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic       exp_valid;
  logic [LW-1:0] exp_idx;
  logic       exp_ready;
  logic       exp_busy;

  // Reference model: tables as plain arrays, flags for commit and flash.
  int  m_act[NL];
  int  m_shd[NL];
  bit  m_act_en[NL];
  bit  m_shd_en[NL];
  bit  m_pend;
  bit  m_flash;
  int  m_fcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_act[i] = i; m_shd[i] = i;
      m_act_en[i] = 1'b1; m_shd_en[i] = 1'b1;
    end
    m_pend = 1'b0; m_flash = 1'b0; m_fcnt = 0;
    exp_q.delete();
  endtask

  // One clock of the model, using the inputs present at the active edge.
  task automatic model_cycle();
    int win;
    logic [7:0] rgb;
    win = -1;
    for (int s = 0; s < NL; s++) begin
      int l;
      l = m_act[s];
      if (win < 0 && l < NL && drawReq[l] && m_act_en[l]) win = l;
    end
    if (m_flash)      rgb = 8'hFF;
    else if (win >= 0) rgb = layerRGB[8*win +: 8];
    else              rgb = backGroundRGB;
    exp_q.push_back(rgb);
    exp_valid = (win >= 0);
    exp_idx   = (win >= 0) ? win[LW-1:0] : '0;
    if (!m_pend && cfg_valid && int'(cfg_slot) < NL && int'(cfg_layer) < NL) begin
      m_shd[cfg_slot]     = int'(cfg_layer);
      m_shd_en[cfg_layer] = cfg_enable;
    end
    if (!m_pend) begin
      if (cfg_commit) m_pend = 1'b1;
    end else if (startOfFrame) begin
      m_act = m_shd; m_act_en = m_shd_en; m_pend = 1'b0;
    end
    if (flash_trigger) begin
      m_flash = 1'b1; m_fcnt = FF;
    end else if (m_flash && startOfFrame) begin
      m_fcnt--;
      if (m_fcnt == 0) m_flash = 1'b0;
    end
    exp_ready = !m_pend;
    exp_busy  = m_pend;
  endtask

  // Driver: inputs are set at the falling edge, outputs checked at the next one.
  task automatic step();
    @(posedge clk);
    model_cycle();
    @(negedge clk);
    check("rgbOut", rgbOut, exp_q.pop_front());
    check("winnerValid", winnerValid, exp_valid);
    check("winnerIdx", winnerIdx, exp_idx);
    check("cfg_ready", cfg_ready, exp_ready);
    check("commitBusy", commitBusy, exp_busy);
  endtask

  task automatic cfg_write(input int slot, input int layer, input bit en);
    cfg_valid = 1'b1; cfg_slot = LW'(slot); cfg_layer = LW'(layer); cfg_enable = en;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic commit_req();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  initial begin
    model_reset();
    for (int l = 0; l < NL; l++) layerRGB[8*l +: 8] = 8'(8'h40 + l);
    layerRGB[15:8]  = 8'h1C;
    layerRGB[23:16] = 8'hE0;
    layerRGB[39:32] = 8'h5A;

    // Reset values
    #1;
    check("rst_rgb", rgbOut, 8'h00);
    check("rst_valid", winnerValid, 1'b0);
    check("rst_idx", winnerIdx, 3'd0);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_busy", commitBusy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;

    // 1: identity table, lowest layer index wins
    drawReq = 8'b0000_0110;
    step();
    check("t1_rgb", rgbOut, 8'h1C);
    check("t1_idx", winnerIdx, 3'd1);
    check("t1_valid", winnerValid, 1'b1);

    // 2: swap priority of layers 1 and 2, applied only after start of frame
    cfg_write(0, 2, 1'b1);
    cfg_write(1, 1, 1'b1);
    commit_req();
    step();
    check("t2_pending_rgb", rgbOut, 8'h1C);
    check("t2_pending_busy", commitBusy, 1'b1);
    sof_pulse();
    check("t2_sof_cycle_rgb", rgbOut, 8'h1C);
    step();
    check("t2_new_rgb", rgbOut, 8'hE0);
    check("t2_ready", cfg_ready, 1'b1);

    // 3: disable layer 2 -> background
    cfg_write(0, 2, 1'b0);
    commit_req();
    step();
    sof_pulse();
    drawReq = 8'b0000_0100;
    step();
    check("t3_rgb", rgbOut, backGroundRGB);
    check("t3_valid", winnerValid, 1'b0);

    // 4: flash for 6 frames, retrigger on pulse 3 stretches to 9
    drawReq = 8'b0000_0110;
    flash_trigger = 1'b1;
    step();
    flash_trigger = 1'b0;
    for (int p = 1; p <= 9; p++) begin
      step();
      check("t4_flash_rgb", rgbOut, 8'hFF);
      step();
      if (p == 3) flash_trigger = 1'b1;
      sof_pulse();
      flash_trigger = 1'b0;
      check("t4_sof_rgb", rgbOut, 8'hFF);
    end
    step();
    check("t4_after_rgb", rgbOut, 8'h1C);

    // 5: write held during PENDING stalls, lands the cycle after start of frame
    commit_req();
    cfg_valid = 1'b1; cfg_slot = 3'd0; cfg_layer = 3'd4; cfg_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_stall_ready", cfg_ready, 1'b0);
    end
    sof_pulse();
    check("t5_ready_after_sof", cfg_ready, 1'b1);
    step();
    cfg_valid = 1'b0;
    commit_req();
    sof_pulse();
    drawReq = 8'b0001_0110;
    step();
    check("t5_new_winner", rgbOut, 8'h5A);
    check("t5_new_idx", winnerIdx, 3'd4);

    // 6: asynchronous reset while commit pending and flash on
    commit_req();
    flash_trigger = 1'b1;
    step();
    flash_trigger = 1'b0;
    step();
    #2 resetN = 1'b0;
    #1;
    check("t6_rst_rgb", rgbOut, 8'h00);
    check("t6_rst_valid", winnerValid, 1'b0);
    check("t6_rst_idx", winnerIdx, 3'd0);
    check("t6_rst_busy", commitBusy, 1'b0);
    check("t6_rst_ready", cfg_ready, 1'b1);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    drawReq = 8'b0000_0110;
    step();
    check("t6_identity_rgb", rgbOut, 8'h1C);
    sof_pulse();
    step();
    check("t6_no_flash_rgb", rgbOut, 8'h1C);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      drawReq       = NL'($urandom);
      layerRGB      = {$urandom(), $urandom()};
      backGroundRGB = 8'($urandom);
      cfg_valid     = ($urandom_range(0, 3) == 0);
      cfg_slot      = LW'($urandom);
      cfg_layer     = LW'($urandom);
      cfg_enable    = ($urandom_range(0, 3) != 0);
      cfg_commit    = ($urandom_range(0, 7) == 0);
      startOfFrame  = ($urandom_range(0, 9) == 0);
      flash_trigger = ($urandom_range(0, 60) == 0);
      step();
    end
    cfg_valid = 1'b0; cfg_commit = 1'b0; startOfFrame = 1'b0; flash_trigger = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
